// File: rtl/sdram_arbit_if.sv
// Bundle of the signals between the SDRAM command arbiter, its four sub-controllers and the pads.
// The arbiter uses modport master. The client and pad side uses modport slave.
interface sdram_arbit_if #(
  parameter int ADDR_W = 12,
  parameter int BANK_W = 2,
  parameter int DQ_W   = 16
);

  // init sub-controller
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic              flag_init_end;

  // auto-refresh sub-controller
  logic              aref_req;
  logic              aref_en;
  logic [3:0]        aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic              flag_aref_end;

  // write sub-controller
  logic              wr_req;
  logic              wr_en;
  logic [3:0]        wr_cmd;
  logic [ADDR_W-1:0] wr_addr;
  logic [BANK_W-1:0] wr_bank;
  logic [DQ_W-1:0]   wr_data;
  logic              flag_wr_end;

  // read sub-controller
  logic              rd_req;
  logic              rd_en;
  logic [3:0]        rd_cmd;
  logic [ADDR_W-1:0] rd_addr;
  logic [BANK_W-1:0] rd_bank;
  logic              flag_rd_end;

  // SDRAM pins and status
  logic              sdram_cke;
  logic              sdram_cs_n;
  logic              sdram_ras_n;
  logic              sdram_cas_n;
  logic              sdram_we_n;
  logic [BANK_W-1:0] sdram_bank;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DQ_W-1:0]   sdram_dq_out;
  logic              sdram_dq_oe;
  logic [4:0]        arb_state;

  modport master (
    input  init_cmd, init_addr, flag_init_end,
    input  aref_req, aref_cmd, aref_addr, flag_aref_end,
    input  wr_req, wr_cmd, wr_addr, wr_bank, wr_data, flag_wr_end,
    input  rd_req, rd_cmd, rd_addr, rd_bank, flag_rd_end,
    output aref_en, wr_en, rd_en,
    output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    output sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe, arb_state
  );

  modport slave (
    output init_cmd, init_addr, flag_init_end,
    output aref_req, aref_cmd, aref_addr, flag_aref_end,
    output wr_req, wr_cmd, wr_addr, wr_bank, wr_data, flag_wr_end,
    output rd_req, rd_cmd, rd_addr, rd_bank, flag_rd_end,
    input  aref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
    input  sdram_bank, sdram_addr, sdram_dq_out, sdram_dq_oe, arb_state
  );

endinterface

// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: grants refresh > write > read, one client at a time,
// and multiplexes the granted client's command/address/bank onto the pins.
module sdram_arbit #(
  parameter int ADDR_W = 12,
  parameter int BANK_W = 2,
  parameter int DQ_W   = 16
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  sdram_arbit_if.master bus
);

  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_AREF  = 5'b00100,
    S_WRITE = 5'b01000,
    S_READ  = 5'b10000
  } state_e;

  localparam logic [3:0] CMD_NOP = 4'b0111;

  state_e            state_q, state_d;
  logic              aref_en_q, aref_en_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              cke_q;

  logic [3:0]        cmd_mux;
  logic [ADDR_W-1:0] addr_mux;
  logic [BANK_W-1:0] bank_mux;
  logic              dq_oe_mux;

  // State register; cke rises on the first clock after reset release.
  always_ff @(posedge sclk) begin
    if (!s_rst_n) begin
      state_q   <= S_INIT;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      cke_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aref_en_q <= aref_en_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      cke_q     <= 1'b1;
    end
  end

  // Grants only leave ARBIT, so every grant is preceded by at least one NOP cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (bus.flag_init_end) state_d = S_ARBIT;
      S_ARBIT: begin
        if (bus.aref_req)    state_d = S_AREF;
        else if (bus.wr_req) state_d = S_WRITE;
        else if (bus.rd_req) state_d = S_READ;
      end
      S_AREF:  if (bus.flag_aref_end) state_d = S_ARBIT;
      S_WRITE: if (bus.flag_wr_end)   state_d = S_ARBIT;
      S_READ:  if (bus.flag_rd_end)   state_d = S_ARBIT;
      default: state_d = S_INIT;
    endcase

    aref_en_d = (state_q == S_ARBIT) && (state_d == S_AREF);
    wr_en_d   = (state_q == S_ARBIT) && (state_d == S_WRITE);
    rd_en_d   = (state_q == S_ARBIT) && (state_d == S_READ);
  end

  // Pin mux from the current state; client outputs are already registered.
  always_comb begin
    cmd_mux   = CMD_NOP;
    addr_mux  = '0;
    bank_mux  = '0;
    dq_oe_mux = 1'b0;
    case (state_q)
      S_INIT: begin
        cmd_mux  = bus.init_cmd;
        addr_mux = bus.init_addr;
      end
      S_AREF: begin
        cmd_mux  = bus.aref_cmd;
        addr_mux = bus.aref_addr;
      end
      S_WRITE: begin
        cmd_mux   = bus.wr_cmd;
        addr_mux  = bus.wr_addr;
        bank_mux  = bus.wr_bank;
        dq_oe_mux = 1'b1;
      end
      S_READ: begin
        cmd_mux  = bus.rd_cmd;
        addr_mux = bus.rd_addr;
        bank_mux = bus.rd_bank;
      end
      default: ;
    endcase
  end

  assign bus.aref_en      = aref_en_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.sdram_cke    = cke_q;
  assign bus.sdram_cs_n   = cmd_mux[3];
  assign bus.sdram_ras_n  = cmd_mux[2];
  assign bus.sdram_cas_n  = cmd_mux[1];
  assign bus.sdram_we_n   = cmd_mux[0];
  assign bus.sdram_addr   = addr_mux;
  assign bus.sdram_bank   = bank_mux;
  assign bus.sdram_dq_out = bus.wr_data;
  assign bus.sdram_dq_oe  = dq_oe_mux;
  assign bus.arb_state    = state_q;

endmodule
